// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - byte-wide UART receiver, 8N1, mid-bit sampling with one-cycle strobes.
// Optional parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_byte #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_rx_byte: CLKS_PER_BIT must be >= 4 and PARITY_ODD must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n, perr_n;
  logic          par_bit, par_n;
  logic          par_bad;
  logic          sync1, rx_s;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  assign par_bad = (^shift) ^ par_bit ^ ODD;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
    par_n   = par_bit;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_CNT) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_CNT) begin
          cnt_n          = '0;
          shift_n[idx]   = rx_s;
          idx_n          = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL_CNT) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == FULL_CNT) begin
          cnt_n  = '0;
          perr_n = par_bad;
          if (!rx_s) begin
            ferr_n  = 1'b1;
            state_n = RECOVER;
          end else begin
            state_n = IDLE;
            if (!par_bad) begin
              valid_n = 1'b1;
              data_n  = shift;
            end
          end
        end
      end
      RECOVER: begin
        // Wait out a break so a stuck-low line is not decoded as 0x00 frames.
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      par_bit   <= 1'b0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      par_bit   <= par_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
      // Registered from the current state so busy stays high through the valid cycle.
      busy      <= (state != IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= perr_n;
  end
`else
  assign parity_err = 1'b0;
  logic unused_perr;
  assign unused_perr = perr_n;
`endif

endmodule
